// File: rtl/openram_wb_test_ctrl.sv
// openram_wb_test_ctrl
// Test controller sitting between the Caravel Wishbone bus, the GPIO pins and
// one OpenRAM single-port SRAM macro.
//   - Wishbone mode (mode_wb_i=1): a register block (CTRL/EXPECT/STATUS) plus
//     a memory window at offsets 0x400-0xFFF that maps onto the SRAM.
//   - GPIO mode (mode_wb_i=0): a serial scan word is shifted in, a rising
//     edge on gpio_sram_load_i fires one SRAM operation from it, and the read
//     data is folded back into the scan word for shifting out.
// Optional feature macro: OPENRAM_CMP_EN
//   defined   -> EXPECT register, CTRL.cmp_en and the sticky done_o mismatch flag
//   undefined -> no compare logic; done_o/STATUS[0] tie to 0, EXPECT and
//                CTRL[1] read as 0.
// Scan word layout, MSB first: {csb, web, wmask[3:0], addr[ADDR_W-1:0], din[31:0]};
// its width is exactly the sum of those fields.

module openram_wb_test_ctrl #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int          ADDR_W   = 8,
  parameter int          DATA_W   = 32
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [DATA_W-1:0] wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [DATA_W-1:0] wbs_dat_o,
  input  logic              mode_wb_i,
  input  logic              gpio_scan_i,
  input  logic              gpio_in_i,
  input  logic              gpio_sram_load_i,
  input  logic              global_csb_i,
  output logic              gpio_out_o,
  output logic              start_o,
  output logic              done_o,
  output logic              sram_csb_o,
  output logic              sram_web_o,
  output logic [3:0]        sram_wmask_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [DATA_W-1:0] sram_din_o,
  input  logic [DATA_W-1:0] sram_dout_i
);

  // Scan word geometry
  localparam int SW            = 6 + ADDR_W + DATA_W;
  localparam int SCAN_ADDR_LSB = DATA_W;
  localparam int SCAN_MASK_LSB = DATA_W + ADDR_W;
  localparam int SCAN_WEB      = SW - 2;
  localparam int SCAN_CSB      = SW - 1;

  // Register word indices (byte offset >> 2)
  localparam logic [9:0] IDX_CTRL   = 10'd0;
  localparam logic [9:0] IDX_EXPECT = 10'd1;
  localparam logic [9:0] IDX_STATUS = 10'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SRAM = 2'd1,
    ST_CAPT = 2'd2
  } state_e;

  // Byte-lane merge for selectively written registers.
  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] new_w,
                                                    input logic [3:0]        sel);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return res;
  endfunction

  // Window FSM and bus-side state
  state_e            state_q, state_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              win_drv_q, win_drv_d;   // window access actually drives the SRAM
  logic              win_rd_q, win_rd_d;     // window access is a read
  logic              start_q, start_d;

  // SRAM port registers
  logic              csb_q, csb_d;
  logic              web_q, web_d;
  logic [3:0]        wmask_q, wmask_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;

  // Scan path
  logic [SW-1:0]     scan_q, scan_d;
  logic              load_q;       // previous gpio_sram_load_i for edge detect
  logic              gsram_q;      // GPIO-launched SRAM cycle is on the pins
  logic              gcapt_q;      // sram_dout_i holds the GPIO result this cycle
  logic              load_rise;

  // Decode
  logic              bus_hit;
  logic              accept;
  logic              is_win;
  logic              win_acc;
  logic              reg_acc;
  logic              reg_wr;
  logic [9:0]        reg_idx;
  logic              unused_adr_lsb;

  assign reg_idx        = wbs_adr_i[11:2];
  assign bus_hit        = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:12] == BASE_ADR[31:12]);
  assign accept         = bus_hit & (state_q == ST_IDLE) & ~ack_q;
  assign is_win         = |wbs_adr_i[11:10];
  assign win_acc        = accept & is_win;
  assign reg_acc        = accept & ~is_win;
  assign reg_wr         = reg_acc & wbs_we_i;
  assign load_rise      = gpio_sram_load_i & ~load_q & ~mode_wb_i;
  assign unused_adr_lsb = ^wbs_adr_i[1:0];

`ifdef OPENRAM_CMP_EN
  logic [DATA_W-1:0] expect_q, expect_d;
  logic              cmp_en_q, cmp_en_d;
  logic              done_q, done_d;

  // Compare configuration and sticky mismatch flag
  always_comb begin
    expect_d = expect_q;
    cmp_en_d = cmp_en_q;
    done_d   = done_q;
    if (reg_wr && reg_idx == IDX_CTRL && wbs_sel_i[0]) cmp_en_d = wbs_dat_i[1];
    if (reg_wr && reg_idx == IDX_EXPECT) expect_d = merge_bytes(expect_q, wbs_dat_i, wbs_sel_i);
    if (reg_wr && reg_idx == IDX_STATUS) done_d = 1'b0;
    // Mismatch is judged in the capture cycle, while the SRAM data is on sram_dout_i.
    if (state_q == ST_CAPT && win_drv_q && win_rd_q && cmp_en_q && (sram_dout_i != expect_q))
      done_d = 1'b1;
  end

  // Compare registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      expect_q <= '0;
      cmp_en_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      expect_q <= expect_d;
      cmp_en_q <= cmp_en_d;
      done_q   <= done_d;
    end
  end
`else
  logic [DATA_W-1:0] expect_q;
  logic              cmp_en_q;
  logic              done_q;

  assign expect_q = '0;
  assign cmp_en_q = 1'b0;
  assign done_q   = 1'b0;
`endif

  // Window FSM state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Window FSM next state: one SRAM cycle, one capture cycle, then idle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (win_acc) state_d = ST_SRAM;
      ST_SRAM: state_d = ST_CAPT;
      ST_CAPT: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: ack, register read data, CTRL and SRAM port next values
  always_comb begin
    ack_d     = reg_acc | (state_q == ST_SRAM);
    rdata_d   = '0;
    start_d   = start_q;
    win_drv_d = win_drv_q;
    win_rd_d  = win_rd_q;
    csb_d     = 1'b1;
    web_d     = 1'b1;
    wmask_d   = 4'h0;
    addr_d    = addr_q;
    din_d     = din_q;

    if (reg_acc && !wbs_we_i) begin
      case (reg_idx)
        IDX_CTRL:   rdata_d = {{(DATA_W-2){1'b0}}, cmp_en_q, start_q};
        IDX_EXPECT: rdata_d = expect_q;
        IDX_STATUS: rdata_d = {{(DATA_W-2){1'b0}}, mode_wb_i, done_q};
        default:    rdata_d = '0;
      endcase
    end

    if (reg_wr && reg_idx == IDX_CTRL && wbs_sel_i[0]) start_d = wbs_dat_i[0];

    if (win_acc) begin
      win_drv_d = mode_wb_i;
      win_rd_d  = ~wbs_we_i;
    end

    // Wishbone owns the SRAM only in Wishbone mode; GPIO launches only in GPIO mode.
    if (win_acc && mode_wb_i) begin
      csb_d   = 1'b0;
      web_d   = ~wbs_we_i;
      wmask_d = wbs_sel_i;
      addr_d  = wbs_adr_i[ADDR_W+1:2];
      din_d   = wbs_dat_i;
    end else if (load_rise) begin
      csb_d   = scan_q[SCAN_CSB] | global_csb_i;
      web_d   = scan_q[SCAN_WEB];
      wmask_d = scan_q[SCAN_MASK_LSB +: 4];
      addr_d  = scan_q[SCAN_ADDR_LSB +: ADDR_W];
      din_d   = scan_q[DATA_W-1:0];
    end
  end

  // Scan register next value: load blocks shifting, readback beats shifting
  always_comb begin
    scan_d = scan_q;
    if (gcapt_q) begin
      scan_d[DATA_W-1:0] = sram_dout_i;
    end else if (gpio_scan_i && !gpio_sram_load_i) begin
      scan_d = {scan_q[SW-2:0], gpio_in_i};
    end
  end

  // Bus-side and SRAM port registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      start_q   <= 1'b0;
      win_drv_q <= 1'b0;
      win_rd_q  <= 1'b0;
      csb_q     <= 1'b1;
      web_q     <= 1'b1;
      wmask_q   <= 4'h0;
      addr_q    <= '0;
      din_q     <= '0;
    end else begin
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      start_q   <= start_d;
      win_drv_q <= win_drv_d;
      win_rd_q  <= win_rd_d;
      csb_q     <= csb_d;
      web_q     <= web_d;
      wmask_q   <= wmask_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
    end
  end

  // Scan shift register, load edge detect and GPIO readback pipeline
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      scan_q  <= '0;
      load_q  <= 1'b0;
      gsram_q <= 1'b0;
      gcapt_q <= 1'b0;
    end else begin
      scan_q  <= scan_d;
      load_q  <= gpio_sram_load_i;
      gsram_q <= load_rise;
      gcapt_q <= gsram_q;
    end
  end

  // Window reads return the live SRAM data during the capture cycle; GPIO-mode
  // window reads fall through to rdata_q, which is zero outside register reads.
  assign wbs_dat_o    = (state_q == ST_CAPT && win_drv_q && win_rd_q) ? sram_dout_i : rdata_q;
  assign wbs_ack_o    = ack_q;
  assign start_o      = start_q;
  assign done_o       = done_q;
  assign gpio_out_o   = scan_q[SW-1];
  assign sram_csb_o   = csb_q;
  assign sram_web_o   = web_q;
  assign sram_wmask_o = wmask_q;
  assign sram_addr_o  = addr_q;
  assign sram_din_o   = din_q;

endmodule

// File: tb/tb_openram_wb_test_ctrl.sv
// Directed testbench for openram_wb_test_ctrl with a behavioural SRAM model.
module tb_openram_wb_test_ctrl;
  localparam int ADDR_W = 8;
  localparam int SW     = 6 + ADDR_W + 32;

  localparam logic [31:0] A_CTRL   = 32'h3000_0000;
  localparam logic [31:0] A_EXPECT = 32'h3000_0004;
  localparam logic [31:0] A_STATUS = 32'h3000_0008;

  logic clk = 1'b0;
  logic rst;
  logic cyc, stb, we;
  logic [3:0] sel;
  logic [31:0] adr, dat_w;
  logic ack;
  logic [31:0] dat_r;
  logic mode_wb, gscan, gin, gload, gcsb;
  logic gout, start, done;
  logic s_csb, s_web;
  logic [3:0] s_wmask;
  logic [ADDR_W-1:0] s_addr;
  logic [31:0] s_din;
  logic [31:0] s_dout;

  logic [31:0] mem [0:255];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  openram_wb_test_ctrl #(
    .BASE_ADR(32'h3000_0000),
    .ADDR_W  (ADDR_W),
    .DATA_W  (32)
  ) dut (
    .wb_clk_i        (clk),
    .wb_rst_i        (rst),
    .wbs_cyc_i       (cyc),
    .wbs_stb_i       (stb),
    .wbs_we_i        (we),
    .wbs_sel_i       (sel),
    .wbs_adr_i       (adr),
    .wbs_dat_i       (dat_w),
    .wbs_ack_o       (ack),
    .wbs_dat_o       (dat_r),
    .mode_wb_i       (mode_wb),
    .gpio_scan_i     (gscan),
    .gpio_in_i       (gin),
    .gpio_sram_load_i(gload),
    .global_csb_i    (gcsb),
    .gpio_out_o      (gout),
    .start_o         (start),
    .done_o          (done),
    .sram_csb_o      (s_csb),
    .sram_web_o      (s_web),
    .sram_wmask_o    (s_wmask),
    .sram_addr_o     (s_addr),
    .sram_din_o      (s_din),
    .sram_dout_i     (s_dout)
  );

  // Single-port SRAM: read data appears one clock after the sampling edge.
  always @(posedge clk) begin
    if (!s_csb) begin
      if (!s_web) begin
        for (int b = 0; b < 4; b++)
          if (s_wmask[b]) mem[s_addr][b*8 +: 8] <= s_din[b*8 +: 8];
      end else begin
        s_dout <= mem[s_addr];
      end
    end
  end

  // One Wishbone classic access; lat = edges from stb to ack, -1 if no ack.
  task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd, output int lat,
                           output logic [ADDR_W-1:0] sa, output logic scsb);
    int n;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    lat = -1; rd = '0; sa = '0; scsb = 1'b1; n = 0;
    while (lat < 0 && n < 6) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin sa = s_addr; scsb = s_csb; end
      if (ack) begin lat = n; rd = dat_r; end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic shift_in(input logic [SW-1:0] w);
    for (int i = SW - 1; i >= 0; i--) begin
      gin = w[i]; gscan = 1'b1;
      @(posedge clk); #1;
    end
    gscan = 1'b0; gin = 1'b0;
  endtask

  task automatic shift_out(output logic [SW-1:0] w);
    for (int i = SW - 1; i >= 0; i--) begin
      w[i] = gout; gin = 1'b0; gscan = 1'b1;
      @(posedge clk); #1;
    end
    gscan = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat_w = 0;
    mode_wb = 1'b1; gscan = 0; gin = 0; gload = 0; gcsb = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", ack); end
    n_tests++; if (dat_r !== 32'h0) begin n_fail++; $display("FAIL reset_dat: got %h want 0", dat_r); end
    n_tests++; if (start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b want 0", start); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_tests++; if (gout !== 1'b0) begin n_fail++; $display("FAIL reset_gout: got %b want 0", gout); end
    n_tests++; if (s_csb !== 1'b1) begin n_fail++; $display("FAIL reset_csb: got %b want 1", s_csb); end
    n_tests++; if (s_web !== 1'b1) begin n_fail++; $display("FAIL reset_web: got %b want 1", s_web); end
    n_tests++; if (s_wmask !== 4'h0) begin n_fail++; $display("FAIL reset_wmask: got %h want 0", s_wmask); end
    n_tests++; if (s_addr !== 8'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", s_addr); end
    n_tests++; if (s_din !== 32'h0) begin n_fail++; $display("FAIL reset_din: got %h want 0", s_din); end
  endtask

  task automatic test_ctrl();
    logic [31:0] rd; int lat; logic [ADDR_W-1:0] sa; logic scsb;
    wb_access(1'b1, A_CTRL, 32'h1, 4'hF, rd, lat, sa, scsb);
    n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL ctrl_wr_lat: got %0d want 1", lat); end
    n_tests++; if (start !== 1'b1) begin n_fail++; $display("FAIL ctrl_start_set: got %b want 1", start); end
    wb_access(1'b0, A_CTRL, 32'h0, 4'hF, rd, lat, sa, scsb);
    n_tests++; if (rd !== 32'h1 || lat !== 1) begin n_fail++; $display("FAIL ctrl_rd: got %h lat %0d want 00000001 lat 1", rd, lat); end
    wb_access(1'b1, A_CTRL, 32'h0, 4'b0010, rd, lat, sa, scsb);
    n_tests++; if (start !== 1'b1) begin n_fail++; $display("FAIL ctrl_sel_mask: got %b want 1", start); end
    wb_access(1'b1, A_CTRL, 32'h0, 4'hF, rd, lat, sa, scsb);
    n_tests++; if (start !== 1'b0) begin n_fail++; $display("FAIL ctrl_start_clr: got %b want 0", start); end
    wb_access(1'b1, 32'h3000_000C, 32'hFFFF_FFFF, 4'hF, rd, lat, sa, scsb);
    wb_access(1'b0, 32'h3000_000C, 32'h0, 4'hF, rd, lat, sa, scsb);
    n_tests++; if (rd !== 32'h0 || lat !== 1) begin n_fail++; $display("FAIL reserved_rd: got %h lat %0d want 0 lat 1", rd, lat); end
  endtask

  task automatic test_window();
    logic [31:0] rd; int lat; logic [ADDR_W-1:0] sa; logic scsb;
    wb_access(1'b1, 32'h3000_0404, 32'hDEAD_BEEF, 4'hF, rd, lat, sa, scsb);
    n_tests++; if (lat !== 2 || sa !== 8'h01 || scsb !== 1'b0) begin n_fail++; $display("FAIL win_wr: got lat %0d addr %h csb %b want lat 2 addr 01 csb 0", lat, sa, scsb); end
    n_tests++; if (mem[1] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL win_wr_mem: got %h want deadbeef", mem[1]); end
    wb_access(1'b0, 32'h3000_0404, 32'h0, 4'hF, rd, lat, sa, scsb);
    n_tests++; if (lat !== 2 || sa !== 8'h01) begin n_fail++; $display("FAIL win_rd_lat: got lat %0d addr %h want lat 2 addr 01", lat, sa); end
    n_tests++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL win_rd_data: got %h want deadbeef", rd); end
  endtask

  task automatic test_bytesel();
    logic [31:0] rd; int lat; logic [ADDR_W-1:0] sa; logic scsb;
    wb_access(1'b1, 32'h3000_0408, 32'h1122_3344, 4'hF, rd, lat, sa, scsb);
    wb_access(1'b1, 32'h3000_0408, 32'h0000_00AA, 4'b0001, rd, lat, sa, scsb);
    wb_access(1'b0, 32'h3000_0408, 32'h0, 4'hF, rd, lat, sa, scsb);
    n_tests++; if (rd !== 32'h1122_33AA) begin n_fail++; $display("FAIL bytesel: got %h want 112233aa", rd); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd; int lat; logic [ADDR_W-1:0] sa; logic scsb;
    wb_access(1'b1, 32'h3000_0FFC, 32'hCAFE_F00D, 4'hF, rd, lat, sa, scsb);
    n_tests++; if (sa !== 8'hFF) begin n_fail++; $display("FAIL wrap_addr: got %h want ff", sa); end
    wb_access(1'b0, 32'h3000_07FC, 32'h0, 4'hF, rd, lat, sa, scsb);
    n_tests++; if (rd !== 32'hCAFE_F00D || sa !== 8'hFF) begin n_fail++; $display("FAIL wrap_rd: got %h addr %h want cafef00d addr ff", rd, sa); end
  endtask

  task automatic test_decode_miss();
    logic [31:0] rd; int lat; logic [ADDR_W-1:0] sa; logic scsb;
    wb_access(1'b0, 32'h3000_1000, 32'h0, 4'hF, rd, lat, sa, scsb);
    n_tests++; if (lat !== -1) begin n_fail++; $display("FAIL miss_above: got lat %0d want no ack", lat); end
    wb_access(1'b1, 32'h2000_0000, 32'h1, 4'hF, rd, lat, sa, scsb);
    n_tests++; if (lat !== -1 || start !== 1'b0) begin n_fail++; $display("FAIL miss_other: got lat %0d start %b want no ack start 0", lat, start); end
  endtask

  task automatic test_compare();
    logic [31:0] rd; int lat; logic [ADDR_W-1:0] sa; logic scsb;
    wb_access(1'b1, 32'h3000_041C, 32'h0000_0054, 4'hF, rd, lat, sa, scsb);
    wb_access(1'b1, 32'h3000_0420, 32'h0000_0055, 4'hF, rd, lat, sa, scsb);
    wb_access(1'b1, A_EXPECT, 32'h0000_0055, 4'hF, rd, lat, sa, scsb);
    wb_access(1'b1, A_CTRL, 32'h2, 4'hF, rd, lat, sa, scsb);
`ifdef OPENRAM_CMP_EN
    wb_access(1'b0, A_EXPECT, 32'h0, 4'hF, rd, lat, sa, scsb);
    n_tests++; if (rd !== 32'h55) begin n_fail++; $display("FAIL expect_rd: got %h want 55", rd); end
    wb_access(1'b0, 32'h3000_041C, 32'h0, 4'hF, rd, lat, sa, scsb);
    n_tests++; if (done !== 1'b1 || rd !== 32'h54) begin n_fail++; $display("FAIL cmp_mismatch: got done %b data %h want done 1 data 54", done, rd); end
    wb_access(1'b0, A_STATUS, 32'h0, 4'hF, rd, lat, sa, scsb);
    n_tests++; if (rd !== 32'h3) begin n_fail++; $display("FAIL status_done: got %h want 3", rd); end
    wb_access(1'b1, A_STATUS, 32'h0, 4'hF, rd, lat, sa, scsb);
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL status_clr: got %b want 0", done); end
    wb_access(1'b0, 32'h3000_0420, 32'h0, 4'hF, rd, lat, sa, scsb);
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL cmp_match: got %b want 0", done); end
`else
    wb_access(1'b0, A_EXPECT, 32'h0, 4'hF, rd, lat, sa, scsb);
    n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL expect_absent: got %h want 0", rd); end
    wb_access(1'b0, A_CTRL, 32'h0, 4'hF, rd, lat, sa, scsb);
    n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL cmpen_absent: got %h want 0", rd); end
    wb_access(1'b0, 32'h3000_041C, 32'h0, 4'hF, rd, lat, sa, scsb);
    n_tests++; if (done !== 1'b0 || rd !== 32'h54) begin n_fail++; $display("FAIL cmp_absent: got done %b data %h want done 0 data 54", done, rd); end
    wb_access(1'b0, A_STATUS, 32'h0, 4'hF, rd, lat, sa, scsb);
    n_tests++; if (rd !== 32'h2) begin n_fail++; $display("FAIL status_nocmp: got %h want 2", rd); end
`endif
    wb_access(1'b1, A_CTRL, 32'h0, 4'hF, rd, lat, sa, scsb);
  endtask

  task automatic test_gpio_window();
    logic [31:0] rd; int lat; logic [ADDR_W-1:0] sa; logic scsb;
    mode_wb = 1'b0;
    wb_access(1'b0, A_STATUS, 32'h0, 4'hF, rd, lat, sa, scsb);
    n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL status_gpio: got %h want 0", rd); end
    wb_access(1'b0, 32'h3000_0404, 32'h0, 4'hF, rd, lat, sa, scsb);
    n_tests++; if (lat !== 2 || rd !== 32'h0 || scsb !== 1'b1) begin n_fail++; $display("FAIL gpio_win_rd: got lat %0d data %h csb %b want lat 2 data 0 csb 1", lat, rd, scsb); end
    wb_access(1'b1, 32'h3000_0404, 32'h1234_5678, 4'hF, rd, lat, sa, scsb);
    n_tests++; if (lat !== 2 || scsb !== 1'b1 || mem[1] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL gpio_win_wr: got lat %0d csb %b mem %h want lat 2 csb 1 mem deadbeef", lat, scsb, mem[1]); end
    mode_wb = 1'b1;
  endtask

  task automatic test_gpio_scan();
    logic [SW-1:0] got;
    mode_wb = 1'b0;
    shift_in({1'b0, 1'b0, 4'hF, 8'h03, 32'hA5A5_A5A5});
    gload = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (s_csb !== 1'b0 || s_web !== 1'b0 || s_wmask !== 4'hF || s_addr !== 8'h03 || s_din !== 32'hA5A5_A5A5)
      begin n_fail++; $display("FAIL scan_wr_fields: got csb %b web %b mask %h addr %h din %h want 0 0 f 03 a5a5a5a5", s_csb, s_web, s_wmask, s_addr, s_din); end
    gload = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (s_csb !== 1'b1) begin n_fail++; $display("FAIL scan_one_cycle: got csb %b want 1", s_csb); end
    @(posedge clk); #1;
    shift_in({1'b0, 1'b1, 4'hF, 8'h03, 32'h0});
    gload = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (s_csb !== 1'b0 || s_web !== 1'b1 || s_addr !== 8'h03) begin n_fail++; $display("FAIL scan_rd_fields: got csb %b web %b addr %h want 0 1 03", s_csb, s_web, s_addr); end
    gload = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    shift_out(got);
    n_tests++; if (got !== {1'b0, 1'b1, 4'hF, 8'h03, 32'hA5A5_A5A5}) begin n_fail++; $display("FAIL scan_readback: got %h want %h", got, {1'b0, 1'b1, 4'hF, 8'h03, 32'hA5A5_A5A5}); end
    mode_wb = 1'b1;
  endtask

  task automatic test_global_csb();
    logic [31:0] rd; int lat; logic [ADDR_W-1:0] sa; logic scsb;
    wb_access(1'b1, 32'h3000_0414, 32'h0, 4'hF, rd, lat, sa, scsb);
    mode_wb = 1'b0; gcsb = 1'b1;
    shift_in({1'b0, 1'b0, 4'hF, 8'h05, 32'h1234_5678});
    gload = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (s_csb !== 1'b1) begin n_fail++; $display("FAIL global_csb: got csb %b want 1", s_csb); end
    gload = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_tests++; if (mem[5] !== 32'h0) begin n_fail++; $display("FAIL global_csb_mem: got %h want 0", mem[5]); end
    gcsb = 1'b0; mode_wb = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; int lat; logic [ADDR_W-1:0] sa; logic scsb; int acks;
    wb_access(1'b1, A_CTRL, 32'h1, 4'hF, rd, lat, sa, scsb);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0404; sel = 4'hF;
    @(posedge clk); #1;
    n_tests++; if (s_csb !== 1'b0) begin n_fail++; $display("FAIL rstmid_inflight: got csb %b want 0", s_csb); end
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (ack !== 1'b0 || dat_r !== 32'h0 || start !== 1'b0 || done !== 1'b0 || gout !== 1'b0)
      begin n_fail++; $display("FAIL rstmid_bus: got ack %b dat %h start %b done %b gout %b want all 0", ack, dat_r, start, done, gout); end
    n_tests++; if (s_csb !== 1'b1 || s_web !== 1'b1 || s_wmask !== 4'h0 || s_addr !== 8'h0 || s_din !== 32'h0)
      begin n_fail++; $display("FAIL rstmid_sram: got csb %b web %b mask %h addr %h din %h want 1 1 0 00 0", s_csb, s_web, s_wmask, s_addr, s_din); end
    rst = 1'b0;
    acks = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    n_tests++; if (acks !== 0) begin n_fail++; $display("FAIL rstmid_noack: got %0d acks want 0", acks); end
  endtask

  initial begin
    test_reset();
    test_ctrl();
    test_window();
    test_bytesel();
    test_wrap();
    test_decode_miss();
    test_compare();
    test_gpio_window();
    test_gpio_scan();
    test_global_csb();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
